// File: rtl/high_score_keeper_if.sv
// Score-report bus between the game controller (master) and the high-score keeper (slave).
interface high_score_keeper_if #(
    parameter int ID_W    = 3,
    parameter int SCORE_W = 7
);
    logic               score_req;
    logic [ID_W-1:0]    player_id;
    logic               is_guest;
    logic [SCORE_W-1:0] score;
    logic               new_high_score;
    logic               valid;
    logic               personalwin;
    logic               globalwin;
    logic [SCORE_W-1:0] global_best;
    logic [ID_W-1:0]    global_holder;
    logic               global_holder_guest;
    logic               busy;

    modport master (
        output score_req, player_id, is_guest, score, new_high_score,
        input  valid, personalwin, globalwin, global_best, global_holder,
               global_holder_guest, busy
    );

    modport slave (
        input  score_req, player_id, is_guest, score, new_high_score,
        output valid, personalwin, globalwin, global_best, global_holder,
               global_holder_guest, busy
    );
endinterface

// File: rtl/high_score_keeper.sv
// High-score keeper: compares a reported score against the per-player and global
// records, answers with a one-cycle verdict strobe, and commits on request.
//
// state   | meaning
// IDLE    | waiting for score_req; commits accepted
// LOOKUP  | compare latched score against table and global best
// RESPOND | valid high with verdicts; commits accepted
module high_score_keeper #(
    parameter int NUM_PLAYERS = 8,
    parameter int SCORE_W     = 7,
    parameter int ID_W        = 3
) (
    input  logic clk,
    input  logic rst,
    high_score_keeper_if.slave bus
);
    localparam int TBL_DEPTH = 2 ** ID_W;
    localparam logic [ID_W:0] NP_W = (ID_W + 1)'(NUM_PLAYERS);

    typedef enum logic [1:0] {IDLE, LOOKUP, RESPOND} state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    id_q;
    logic               guest_q;
    logic [SCORE_W-1:0] score_q;
    logic               pwin_q, gwin_q;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               commit_ok_q;
    logic [SCORE_W-1:0] table_q [TBL_DEPTH];
    logic [SCORE_W-1:0] gbest_q;
    logic [ID_W-1:0]    gholder_q;
    logic               gguest_q;

    logic capture, lookup, commit;
    logic id_ok, pwin_n, gwin_n;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.score_req) state_d = LOOKUP;
            LOOKUP:  state_d = RESPOND;
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        capture = (state_q == IDLE) && bus.score_req;
        lookup  = (state_q == LOOKUP);
        commit  = bus.new_high_score && commit_ok_q && (state_q != LOOKUP);
        valid_d = (state_d == RESPOND);
        busy_d  = (state_d != IDLE);
    end

    // Slots beyond NUM_PLAYERS exist only to keep indexing in range; they stay 0.
    assign id_ok  = {1'b0, id_q} < NP_W;
    assign pwin_n = id_ok && !guest_q && (score_q > table_q[id_q]);
    assign gwin_n = score_q > gbest_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            id_q        <= '0;
            guest_q     <= 1'b0;
            score_q     <= '0;
            pwin_q      <= 1'b0;
            gwin_q      <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            commit_ok_q <= 1'b0;
            gbest_q     <= '0;
            gholder_q   <= '0;
            gguest_q    <= 1'b0;
            for (int i = 0; i < TBL_DEPTH; i++) table_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            busy_q  <= busy_d;
            if (capture) begin
                id_q    <= bus.player_id;
                guest_q <= bus.is_guest;
                score_q <= bus.score;
            end
            if (lookup) begin
                pwin_q      <= pwin_n;
                gwin_q      <= gwin_n;
                commit_ok_q <= pwin_n || gwin_n;
            end else if (capture || commit) begin
                commit_ok_q <= 1'b0;
            end
            // Commit uses the previous request's latched fields even when a new one is captured.
            if (commit) begin
                if (pwin_q && id_ok) table_q[id_q] <= score_q;
                if (gwin_q) begin
                    gbest_q   <= score_q;
                    gholder_q <= id_q;
                    gguest_q  <= guest_q;
                end
            end
        end
    end

    assign bus.valid               = valid_q;
    assign bus.personalwin         = pwin_q;
    assign bus.globalwin           = gwin_q;
    assign bus.global_best         = gbest_q;
    assign bus.global_holder       = gholder_q;
    assign bus.global_holder_guest = gguest_q;
    assign bus.busy                = busy_q;
endmodule

// File: tb/tb_high_score_keeper.sv
// Self-checking bench for high_score_keeper against a transaction-level record model.
module tb_high_score_keeper;
    localparam int NP = 6;
    localparam int SW = 7;
    localparam int IW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    high_score_keeper_if #(.ID_W(IW), .SCORE_W(SW)) bus ();

    high_score_keeper #(.NUM_PLAYERS(NP), .SCORE_W(SW), .ID_W(IW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk = 0;
    int n_err = 0;

    // Record model: best score per player, global record, and the pending result.
    int m_table[8];
    int m_gbest, m_holder, m_hguest;
    bit m_ok, m_p, m_g;
    int m_id, m_guest, m_score;

    function automatic void model_reset();
        foreach (m_table[i]) m_table[i] = 0;
        m_gbest = 0; m_holder = 0; m_hguest = 0;
        m_ok = 0; m_p = 0; m_g = 0;
        m_id = 0; m_guest = 0; m_score = 0;
    endfunction

    function automatic void model_lookup(int id, int g, int s);
        m_id = id; m_guest = g; m_score = s;
        m_p = (g == 0) && (id < NP) && (s > m_table[id]);
        m_g = s > m_gbest;
        m_ok = m_p || m_g;
    endfunction

    function automatic void model_commit();
        if (m_ok) begin
            if (m_p) m_table[m_id] = m_score;
            if (m_g) begin
                m_gbest = m_score; m_holder = m_id; m_hguest = m_guest;
            end
        end
        m_ok = 0;
    endfunction

    // All stimulus tasks start and end just after a falling edge.
    task automatic run_req(input int id, input int g, input int s, input bit nhs,
                           output bit tok, output logic p, output logic gw);
        bus.score_req = 1'b1;
        bus.player_id = IW'(id);
        bus.is_guest = (g != 0);
        bus.score = SW'(s);
        bus.new_high_score = nhs;
        @(posedge clk); @(negedge clk);
        bus.score_req = 1'b0;
        bus.new_high_score = 1'b0;
        tok = (bus.valid === 1'b0) && (bus.busy === 1'b1);
        @(posedge clk); @(negedge clk);
        tok = tok && (bus.valid === 1'b1);
        p = bus.personalwin;
        gw = bus.globalwin;
        @(posedge clk); @(negedge clk);
        tok = tok && (bus.valid === 1'b0) && (bus.busy === 1'b0);
    endtask

    task automatic do_commit();
        bus.new_high_score = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.new_high_score = 1'b0;
    endtask

    task automatic test_reset();
        bus.score_req = 1'b0; bus.player_id = '0; bus.is_guest = 1'b0;
        bus.score = '0; bus.new_high_score = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++; if (bus.valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.valid); end
        n_chk++; if (bus.personalwin !== 1'b0) begin n_err++; $display("FAIL reset_pwin: got %b want 0", bus.personalwin); end
        n_chk++; if (bus.globalwin !== 1'b0) begin n_err++; $display("FAIL reset_gwin: got %b want 0", bus.globalwin); end
        n_chk++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_chk++; if (bus.global_best !== '0) begin n_err++; $display("FAIL reset_gbest: got %0d want 0", bus.global_best); end
        n_chk++; if (bus.global_holder !== '0) begin n_err++; $display("FAIL reset_holder: got %0d want 0", bus.global_holder); end
        n_chk++; if (bus.global_holder_guest !== 1'b0) begin n_err++; $display("FAIL reset_hguest: got %b want 0", bus.global_holder_guest); end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_directed();
        int   d_id [8] = '{2, 2, 5, 5, 3, 3, 6, 7};
        int   d_g  [8] = '{0, 0, 0, 0, 1, 0, 0, 0};
        int   d_s  [8] = '{10, 10, 7, 7, 50, 20, 60, 61};
        bit   d_c  [8] = '{1, 1, 1, 0, 1, 1, 1, 1};
        bit   tok;
        logic p, gw;
        for (int i = 0; i < 8; i++) begin
            run_req(d_id[i], d_g[i], d_s[i], 1'b0, tok, p, gw);
            model_lookup(d_id[i], d_g[i], d_s[i]);
            n_chk++; if (!tok) begin n_err++; $display("FAIL dir%0d_timing: valid/busy sequence wrong", i); end
            n_chk++; if (p !== m_p) begin n_err++; $display("FAIL dir%0d_pwin: got %b want %b", i, p, m_p); end
            n_chk++; if (gw !== m_g) begin n_err++; $display("FAIL dir%0d_gwin: got %b want %b", i, gw, m_g); end
            if (d_c[i]) begin
                do_commit();
                model_commit();
            end
            n_chk++; if (bus.global_best !== SW'(m_gbest)) begin n_err++; $display("FAIL dir%0d_gbest: got %0d want %0d", i, bus.global_best, m_gbest); end
            n_chk++; if (bus.global_holder !== IW'(m_holder)) begin n_err++; $display("FAIL dir%0d_holder: got %0d want %0d", i, bus.global_holder, m_holder); end
            n_chk++; if (bus.global_holder_guest !== (m_hguest != 0)) begin n_err++; $display("FAIL dir%0d_hguest: got %b want %0d", i, bus.global_holder_guest, m_hguest); end
        end
    endtask

    task automatic test_busy_ignore();
        int pulses = 0;
        bus.score_req = 1'b1; bus.player_id = 3'd1; bus.is_guest = 1'b0; bus.score = 7'd5;
        @(posedge clk); @(negedge clk);
        bus.player_id = 3'd0; bus.score = 7'd127;
        @(posedge clk); @(negedge clk);
        bus.score_req = 1'b0;
        model_lookup(1, 0, 5);
        n_chk++; if (bus.valid !== 1'b1) begin n_err++; $display("FAIL busy_valid: got %b want 1", bus.valid); end
        n_chk++; if (bus.globalwin !== m_g) begin n_err++; $display("FAIL busy_gwin: got %b want %b", bus.globalwin, m_g); end
        n_chk++; if (bus.personalwin !== m_p) begin n_err++; $display("FAIL busy_pwin: got %b want %b", bus.personalwin, m_p); end
        repeat (8) begin
            @(posedge clk); @(negedge clk);
            if (bus.valid === 1'b1) pulses++;
        end
        n_chk++; if (pulses != 0) begin n_err++; $display("FAIL busy_extra_pulses: got %0d want 0", pulses); end
    endtask

    task automatic test_double_commit();
        bit   tok;
        logic p, gw;
        run_req(1, 0, 70, 1'b0, tok, p, gw);
        model_lookup(1, 0, 70);
        n_chk++; if (!tok || gw !== m_g || p !== m_p) begin n_err++; $display("FAIL dbl_verdict: tok=%b p=%b g=%b want p=%b g=%b", tok, p, gw, m_p, m_g); end
        do_commit(); model_commit();
        do_commit(); model_commit();
        n_chk++; if (bus.global_best !== SW'(m_gbest)) begin n_err++; $display("FAIL dbl_gbest: got %0d want %0d", bus.global_best, m_gbest); end
        n_chk++; if (bus.global_holder !== IW'(m_holder)) begin n_err++; $display("FAIL dbl_holder: got %0d want %0d", bus.global_holder, m_holder); end
        run_req(1, 0, 70, 1'b0, tok, p, gw);
        model_lookup(1, 0, 70);
        n_chk++; if (p !== m_p || gw !== m_g) begin n_err++; $display("FAIL dbl_tie: p=%b g=%b want p=%b g=%b", p, gw, m_p, m_g); end
    endtask

    task automatic test_commit_with_req();
        bit   tok;
        logic p, gw;
        run_req(4, 0, 80, 1'b0, tok, p, gw);
        model_lookup(4, 0, 80);
        n_chk++; if (!tok || gw !== m_g) begin n_err++; $display("FAIL cwr_first: tok=%b g=%b want g=%b", tok, gw, m_g); end
        run_req(0, 0, 75, 1'b1, tok, p, gw);
        model_commit();
        model_lookup(0, 0, 75);
        n_chk++; if (!tok) begin n_err++; $display("FAIL cwr_timing: valid/busy sequence wrong"); end
        n_chk++; if (gw !== m_g) begin n_err++; $display("FAIL cwr_gwin: got %b want %b", gw, m_g); end
        n_chk++; if (p !== m_p) begin n_err++; $display("FAIL cwr_pwin: got %b want %b", p, m_p); end
        n_chk++; if (bus.global_best !== SW'(m_gbest)) begin n_err++; $display("FAIL cwr_gbest: got %0d want %0d", bus.global_best, m_gbest); end
    endtask

    task automatic test_reset_in_lookup();
        int   pulses = 0;
        bit   tok;
        logic p, gw;
        bus.score_req = 1'b1; bus.player_id = 3'd2; bus.is_guest = 1'b0; bus.score = 7'd100;
        @(posedge clk); @(negedge clk);
        bus.score_req = 1'b0;
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        model_reset();
        n_chk++; if (bus.global_best !== '0) begin n_err++; $display("FAIL rstl_gbest: got %0d want 0", bus.global_best); end
        n_chk++; if (bus.busy !== 1'b0 || bus.personalwin !== 1'b0 || bus.globalwin !== 1'b0) begin n_err++; $display("FAIL rstl_outs: busy=%b p=%b g=%b want 0", bus.busy, bus.personalwin, bus.globalwin); end
        repeat (4) begin
            if (bus.valid === 1'b1) pulses++;
            @(posedge clk); @(negedge clk);
        end
        n_chk++; if (pulses != 0) begin n_err++; $display("FAIL rstl_pulses: got %0d want 0", pulses); end
        run_req(2, 0, 0, 1'b0, tok, p, gw);
        model_lookup(2, 0, 0);
        n_chk++; if (!tok || p !== m_p || gw !== m_g) begin n_err++; $display("FAIL rstl_zero: tok=%b p=%b g=%b want p=%b g=%b", tok, p, gw, m_p, m_g); end
    endtask

    task automatic test_random();
        bit   tok;
        logic p, gw;
        int   id, g, s, c;
        for (int i = 0; i < 60; i++) begin
            id = int'($urandom_range(0, 7));
            g  = ($urandom_range(0, 3) == 0) ? 1 : 0;
            s  = int'($urandom_range(0, 127));
            c  = int'($urandom_range(0, 2));
            run_req(id, g, s, 1'b0, tok, p, gw);
            model_lookup(id, g, s);
            n_chk++; if (!tok || p !== m_p || gw !== m_g) begin n_err++; $display("FAIL rnd%0d_verdict: id=%0d g=%0d s=%0d tok=%b p=%b gw=%b want p=%b gw=%b", i, id, g, s, tok, p, gw, m_p, m_g); end
            if (c != 0) begin do_commit(); model_commit(); end
            if (c == 2) begin do_commit(); model_commit(); end
            n_chk++; if (bus.global_best !== SW'(m_gbest) || bus.global_holder !== IW'(m_holder) || bus.global_holder_guest !== (m_hguest != 0)) begin
                n_err++;
                $display("FAIL rnd%0d_globals: got %0d/%0d/%b want %0d/%0d/%0d", i, bus.global_best, bus.global_holder, bus.global_holder_guest, m_gbest, m_holder, m_hguest);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_directed();
        test_busy_ignore();
        test_double_commit();
        test_commit_with_req();
        test_reset_in_lookup();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/high_score_keeper.md
Name: high_score_keeper

Overview:
- Responder for the game controller's score-report interface.
- The controller requests a compare with a player ID, a guest flag and a 7-bit score. This block answers with a one-cycle valid strobe carrying the personal-win and global-win verdicts.
- The controller then commits the result with a new-high-score strobe.
- Holds the per-player best-score table and the global best score with its holder, and exposes the global record for display.

Parameters:
- NUM_PLAYERS, 8, number of registered player slots, indexed by player_id.
- SCORE_W, 7, score width in bits.
- ID_W, 3, player ID width; NUM_PLAYERS <= 2**ID_W.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- score_req  input  1  single-cycle compare request.
- player_id  input  ID_W  player issuing the request; sampled with score_req.
- is_guest  input  1  requester is a guest; sampled with score_req.
- score  input  SCORE_W  final score to compare; sampled with score_req.
- new_high_score  input  1  single-cycle commit strobe for the last compared result.
- valid  output  1  one-cycle response strobe.
- personalwin  output  1  score beat the player's stored best; meaningful while valid=1, held afterwards.
- globalwin  output  1  score beat the global best; meaningful while valid=1, held afterwards.
- global_best  output  SCORE_W  current global best score.
- global_holder  output  ID_W  player holding global_best.
- global_holder_guest  output  1  global_best is held by a guest.
- busy  output  1  high while not in IDLE.

Behaviour:
- Reset, applied at any rising edge with rst=1 and in any state:
  - All table entries, global_best, global_holder and global_holder_guest clear to 0.
  - valid, personalwin, globalwin and busy clear to 0.
  - The commit-eligible flag clears; FSM goes to IDLE.
  - Any in-flight request is dropped and produces no valid.
- FSM states: IDLE, LOOKUP, RESPOND.
- IDLE:
  - On score_req=1, latch player_id, is_guest and score, then go to LOOKUP.
  - Clear commit_ok on the same edge.
- LOOKUP, one cycle:
  - personalwin_n = !guest_l && (score_l > table[id_l]).
  - globalwin_n = (score_l > global_best).
  - Register both verdicts and set valid=1, then go to RESPOND.
  - Set commit_ok = personalwin_n || globalwin_n.
- RESPOND: valid=1 for exactly this one cycle; go to IDLE next edge with valid=0.
- Latency: score_req sampled at edge N gives valid=1 in the cycle after edge N+1, dropping at edge N+2.
- Compares are strict greater-than. A tie is not a win, so a score of 0 never wins against the reset table.
- Guests never set personalwin and never write the table. A guest can still set globalwin; on commit the holder becomes player_id with global_holder_guest=1.
- Commit, sampled in IDLE or RESPOND:
  - new_high_score=1 with commit_ok=1: if personalwin is registered, write table[id_l] <= score_l. If globalwin is registered, write global_best <= score_l, global_holder <= id_l and global_holder_guest <= guest_l.
  - Clear commit_ok, so a second commit strobe has no effect.
  - new_high_score with commit_ok=0, or while in LOOKUP, is ignored.
- score_req while busy (LOOKUP or RESPOND) is ignored and not queued.
- new_high_score and score_req on the same IDLE edge: the commit write happens first and the new request is latched. The LOOKUP that follows reads the updated values.
- player_id >= NUM_PLAYERS: personalwin is forced to 0 and the table is never written. globalwin behaves normally.
- Outputs are registered; no combinational path from any input to any output.

Test Plan:
- Reset, then req(id=2, guest=0, score=10) gives valid one cycle, two edges after req, with personalwin=1 and globalwin=1. Commit gives table[2]=10, global_best=10, global_holder=2.
- Same player, req score=10 (tie), gives personalwin=0 and globalwin=0. A following commit leaves global_best=10 unchanged.
- id=5 req score=7 with global_best=10 gives personalwin=1, globalwin=0. Commit sets table[5]=7 and leaves global_best=10, holder=2.
- Guest req score=50 gives personalwin=0, globalwin=1. Commit gives global_best=50, global_holder_guest=1, and the table is unchanged.
- score_req pulsed during LOOKUP is ignored: exactly one valid pulse. A double new_high_score strobe commits once. Commit asserted simultaneously with a new req: the new LOOKUP sees the updated global_best.
- rst asserted during LOOKUP gives no valid pulse, all outputs 0, and global_best=0. Req score=0 afterwards gives valid with both wins 0.
